// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and sizing for the cache-to-memory arbiter.
package arbiter_types;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int LINE_BYTES  = LINE_W / 8;

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;
  typedef enum logic {INST, DATA} arb_port_t;

  // Clears the byte-offset bits so every burst starts on a line boundary
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/line_beat_adaptor.sv
// Converts between one cache line and a burst of narrower memory beats.
module line_beat_adaptor
  import arbiter_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic [LINE_W-1:0] line_in,
  input  logic [BEAT_W-1:0] beat_rdata,
  input  logic              beat_resp,
  output logic [BEAT_W-1:0] beat_wdata,
  output logic [LINE_W-1:0] line_out,
  output logic              last
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              write_q, write_d;

  // A grant restarts the count; each accepted beat advances it and, on reads, lands in its slot
  always_comb begin
    count_d = count_q;
    line_d  = line_q;
    write_d = write_q;
    if (start) begin
      count_d = '0;
      write_d = is_write;
      if (is_write) begin
        line_d = line_in;
      end
    end else if (beat_resp) begin
      count_d = count_q + CNT_W'(1);
      if (!write_q) begin
        line_d[count_q*BEAT_W +: BEAT_W] = beat_rdata;
      end
    end
  end

  // Holds the beat counter and the shared line buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      line_q  <= '0;
      write_q <= 1'b0;
    end else begin
      count_q <= count_d;
      line_q  <= line_d;
      write_q <= write_d;
    end
  end

  assign beat_wdata = line_q[count_q*BEAT_W +: BEAT_W];
  assign line_out   = line_d;
  assign last       = (count_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter turning icache/dcache line requests into memory bursts.
module cache_mem_arbiter
  import arbiter_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q;
  arb_port_t         lastGrant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pmemRead_q, pmemWrite_q, iResp_q, dResp_q;
  logic [LINE_W-1:0] iRdata_q, dRdata_q;

  logic              iReq, dReq, contention, grantData, grantInst;
  logic              startBurst, startWrite, burstActive, beatResp, lastBeat;
  logic [BEAT_W-1:0] beatWdata;
  logic [LINE_W-1:0] lineOut;

  // Chooses the winner in IDLE; on contention the port not served last time wins
  always_comb begin
    iReq        = i_read;
    dReq        = d_read | d_write;
    contention  = iReq & dReq;
    grantData   = (state_q == IDLE) && dReq && (!iReq || lastGrant_q == INST);
    grantInst   = (state_q == IDLE) && iReq && !grantData;
    startBurst  = grantData | grantInst;
    startWrite  = grantData & d_write;
    burstActive = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    beatResp    = burstActive & pmem_resp;
  end

  line_beat_adaptor u_adaptor (
    .clk        (clk),
    .rst        (rst),
    .start      (startBurst),
    .is_write   (startWrite),
    .line_in    (d_wdata),
    .beat_rdata (pmem_rdata),
    .beat_resp  (beatResp),
    .beat_wdata (beatWdata),
    .line_out   (lineOut),
    .last       (lastBeat)
  );

  // Burst sequencing FSM with all handshake outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lastGrant_q <= INST;
      addr_q      <= '0;
      pmemRead_q  <= 1'b0;
      pmemWrite_q <= 1'b0;
      iResp_q     <= 1'b0;
      dResp_q     <= 1'b0;
      iRdata_q    <= '0;
      dRdata_q    <= '0;
    end else begin
      iResp_q <= 1'b0;
      dResp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantData) begin
            state_q     <= d_write ? D_WR : D_RD;
            addr_q      <= line_align(d_address);
            pmemWrite_q <= d_write;
            pmemRead_q  <= ~d_write;
            if (contention) lastGrant_q <= DATA;
          end else if (grantInst) begin
            state_q    <= I_RD;
            addr_q     <= line_align(i_address);
            pmemRead_q <= 1'b1;
            if (contention) lastGrant_q <= INST;
          end
        end
        I_RD, D_RD, D_WR: begin
          if (pmem_resp && lastBeat) begin
            state_q     <= DONE;
            pmemRead_q  <= 1'b0;
            pmemWrite_q <= 1'b0;
            if (state_q == I_RD) begin
              iResp_q  <= 1'b1;
              iRdata_q <= lineOut;
            end else begin
              dResp_q <= 1'b1;
              if (state_q == D_RD) dRdata_q <= lineOut;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_rdata      = iRdata_q;
  assign i_resp       = iResp_q;
  assign d_rdata      = dRdata_q;
  assign d_resp       = dResp_q;
  assign pmem_address = addr_q;
  assign pmem_read    = pmemRead_q;
  assign pmem_write   = pmemWrite_q;
  assign pmem_wdata   = pmemWrite_q ? beatWdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized scoreboard bench for cache_mem_arbiter with a behavioural memory model.
module tb_cache_mem_arbiter;

  typedef struct {
    logic [31:0]  addr;
    bit           isWrite;
    logic [255:0] line;
  } burst_t;

  typedef struct {
    bit           isWrite;
    logic [255:0] line;
  } dexp_t;

  logic         clk, rst;
  logic [31:0]  i_address, d_address, pmem_address;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [63:0]  pmem_wdata, pmem_rdata;

  int totalCount = 0;
  int badCount   = 0;
  int cycleCnt   = 0;
  int lastBeatCyc = 0;
  int memCnt     = 0;
  bit gapMode    = 0;
  bit lastIsData = 0;

  burst_t       burstQ[$];
  logic [255:0] iQ[$];
  dexp_t        dQ[$];
  logic [255:0] physMem  [logic [31:0]];
  logic [255:0] modelMem [logic [31:0]];

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Free-running clock and cycle counter used for response-latency checks
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic reportFail(input string name);
    totalCount++;
    badCount++;
    $display("[TB] FAIL %s (condition not met at cycle %0d)", name, cycleCnt);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  // Deterministic background contents for any line never written
  function automatic logic [255:0] lineInit(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = a * 32'h9E3779B1 + 32'(k) * 32'h01010101 + 32'h1357;
    return l;
  endfunction

  function automatic logic [255:0] modelRead(input logic [31:0] a);
    if (modelMem.exists(a)) return modelMem[a];
    return lineInit(a);
  endfunction

  function automatic logic [255:0] physRead(input logic [31:0] a);
    if (physMem.exists(a)) return physMem[a];
    return lineInit(a);
  endfunction

  // Raises requests and records, in grant order, what the arbiter should do with them
  task automatic applyStimulus(input bit doI, input logic [31:0] iAddr, input bit doD, input bit dWr,
                               input bit dRd, input logic [31:0] dAddr, input logic [255:0] dData);
    burst_t ib, db;
    dexp_t  de;
    logic [31:0] ia, da;
    ia = iAddr & ~32'd31;
    da = dAddr & ~32'd31;
    ib = '{addr: ia, isWrite: 1'b0, line: '0};
    db = '{addr: da, isWrite: dWr, line: dWr ? dData : 256'd0};
    if (doI) iQ.push_back(modelRead(ia));
    if (doD) begin
      de.isWrite = dWr;
      de.line    = dWr ? dData : modelRead(da);
      dQ.push_back(de);
      if (dWr) modelMem[da] = dData;
    end
    if (doI && doD) begin
      if (lastIsData) begin
        burstQ.push_back(ib); burstQ.push_back(db); lastIsData = 1'b0;
      end else begin
        burstQ.push_back(db); burstQ.push_back(ib); lastIsData = 1'b1;
      end
    end else if (doI) begin
      burstQ.push_back(ib);
    end else if (doD) begin
      burstQ.push_back(db);
    end
    i_address = iAddr;
    d_address = dAddr;
    d_wdata   = dData;
    i_read    = doI;
    d_write   = doD & dWr;
    d_read    = doD & (dRd | ~dWr);
  endtask

  task automatic doReset();
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    iQ.delete(); dQ.delete(); burstQ.delete();
    lastIsData = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Holds requests until their responses arrive, then drops them like a cache would
  task automatic runUntilIdle(input int maxCyc, input int dropIAfter);
    bit dropI, dropD, done;
    done = 1'b0;
    for (int c = 0; c < maxCyc && !done; c++) begin
      dropI = 1'b0; dropD = 1'b0;
      @(negedge clk);
      if (i_resp) dropI = 1'b1;
      if (d_resp) dropD = 1'b1;
      if (dropIAfter >= 0 && i_read && pmem_read && memCnt > dropIAfter) dropI = 1'b1;
      @(posedge clk); #1;
      if (dropI) i_read = 1'b0;
      if (dropD) begin d_read = 1'b0; d_write = 1'b0; end
      if (!i_read && !d_read && !d_write && iQ.size() == 0 && dQ.size() == 0 && burstQ.size() == 0)
        done = 1'b1;
    end
    if (!done) begin
      reportFail("burst_timeout");
      doReset();
    end
  endtask

  // Memory model: answers bursts with random or alternating beats and checks burst shape
  initial begin : memory_model
    burst_t cur;
    logic [255:0] tmp;
    bit active, wasActive, give;
    cur = '{addr: '0, isWrite: 1'b0, line: '0};
    wasActive = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        pmem_resp = 1'b0; memCnt = 0; wasActive = 1'b0;
        continue;
      end
      active = pmem_read | pmem_write;
      if (pmem_read && pmem_write) reportFail("pmem_read_and_write");
      if (active && !wasActive) begin
        memCnt = 0;
        if (burstQ.size() == 0) reportFail("burst_unexpected");
        else begin
          cur = burstQ.pop_front();
          checkOutput("burst_addr", 256'(pmem_address), 256'(cur.addr));
          checkOutput("burst_is_write", 256'(pmem_write), 256'(cur.isWrite));
          checkOutput("burst_is_read", 256'(pmem_read), 256'(!cur.isWrite));
        end
      end
      wasActive = active;
      if (active) begin
        if (pmem_address !== cur.addr) checkOutput("addr_held", 256'(pmem_address), 256'(cur.addr));
        if (pmem_write && memCnt < 4) checkOutput("wdata_beat", 256'(pmem_wdata), 256'(cur.line[64*memCnt +: 64]));
        give = (memCnt < 4) && (gapMode ? !pmem_resp : ($urandom_range(0, 2) != 0));
        if (give) begin
          tmp = physRead(cur.addr);
          if (pmem_read) pmem_rdata = tmp[64*memCnt +: 64];
          else begin
            tmp[64*memCnt +: 64] = pmem_wdata;
            physMem[cur.addr] = tmp;
            pmem_rdata = {$urandom, $urandom};
          end
          pmem_resp = 1'b1;
          if (memCnt == 3) lastBeatCyc = cycleCnt;
          memCnt++;
        end else begin
          pmem_resp = 1'b0;
          pmem_rdata = {$urandom, $urandom};
        end
      end else begin
        memCnt = 0;
        pmem_resp = ($urandom_range(0, 3) == 0);
        pmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // Response monitor: pops expected lines and checks one-cycle pulses
  initial begin : resp_monitor
    logic [255:0] e;
    dexp_t de;
    bit prevI, prevD;
    prevI = 1'b0; prevD = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin prevI = 1'b0; prevD = 1'b0; continue; end
      if (i_resp && d_resp) reportFail("both_resp");
      if (i_resp) begin
        if (prevI) reportFail("i_resp_width");
        else if (iQ.size() == 0) reportFail("i_resp_unexpected");
        else begin
          e = iQ.pop_front();
          checkOutput("i_rdata", i_rdata, e);
          checkOutput("i_resp_latency", 256'(cycleCnt), 256'(lastBeatCyc + 1));
        end
      end
      if (d_resp) begin
        if (prevD) reportFail("d_resp_width");
        else if (dQ.size() == 0) reportFail("d_resp_unexpected");
        else begin
          de = dQ.pop_front();
          if (!de.isWrite) checkOutput("d_rdata", d_rdata, de.line);
          checkOutput("d_resp_latency", 256'(cycleCnt), 256'(lastBeatCyc + 1));
        end
      end
      prevI = i_resp; prevD = d_resp;
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin : stimulus
    logic [255:0] wline;
    logic [31:0] ia, da;
    int mode;
    bit dw, dr, hit;
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    physMem[32'h1220]  = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    modelMem[32'h1220] = physMem[32'h1220];

    @(negedge clk);
    checkOutput("reset_pmem_read", 256'(pmem_read), 0);
    checkOutput("reset_pmem_write", 256'(pmem_write), 0);
    checkOutput("reset_pmem_address", 256'(pmem_address), 0);
    checkOutput("reset_i_resp", 256'(i_resp), 0);
    checkOutput("reset_d_resp", 256'(d_resp), 0);
    checkOutput("reset_i_rdata", i_rdata, 0);
    checkOutput("reset_d_rdata", d_rdata, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    gapMode = 1'b1;
    applyStimulus(1, 32'h0000_1234, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pmem_read_before_grant", 256'(pmem_read), 0);
    @(negedge clk);
    checkOutput("pmem_read_after_grant", 256'(pmem_read), 1);
    checkOutput("pmem_address_aligned", 256'(pmem_address), 256'(32'h0000_1220));
    @(posedge clk); #1;
    runUntilIdle(200, -1);
    checkOutput("i_rdata_directed", i_rdata,
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});

    wline = {64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 64'h7654321089ABCDEF};
    applyStimulus(0, 0, 1, 1, 0, 32'h40, wline);
    runUntilIdle(200, -1);
    applyStimulus(0, 0, 1, 0, 1, 32'h44, 0);
    runUntilIdle(200, -1);

    doReset();
    applyStimulus(1, 32'h0001_0040, 1, 0, 1, 32'h0002_0020, 0);
    runUntilIdle(300, -1);
    applyStimulus(1, 32'h0001_0060, 1, 0, 1, 32'h0002_0040, 0);
    runUntilIdle(300, -1);

    applyStimulus(0, 0, 1, 1, 1, 32'h80, {8{32'hA5C3_0F96}});
    runUntilIdle(200, -1);

    applyStimulus(1, 32'h0000_0300, 0, 0, 0, 0, 0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (pmem_read && memCnt == 3) hit = 1'b1;
    end
    if (!hit) reportFail("reach_beat2");
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_pmem_read", 256'(pmem_read), 0);
    checkOutput("async_rst_pmem_write", 256'(pmem_write), 0);
    checkOutput("async_rst_pmem_address", 256'(pmem_address), 0);
    checkOutput("async_rst_pmem_wdata", 256'(pmem_wdata), 0);
    checkOutput("async_rst_i_rdata", i_rdata, 0);
    checkOutput("async_rst_d_rdata", d_rdata, 0);
    checkOutput("async_rst_resp", 256'({i_resp, d_resp}), 0);
    i_read = 1'b0;
    iQ.delete(); dQ.delete(); burstQ.delete();
    lastIsData = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_reset", 256'({pmem_read, pmem_write}), 0);
    @(posedge clk); #1;
    applyStimulus(1, 32'h0000_0300, 0, 0, 0, 0, 0);
    runUntilIdle(200, -1);

    applyStimulus(1, 32'h0000_0500, 0, 0, 0, 0, 0);
    runUntilIdle(200, 1);

    gapMode = 1'b0;
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      ia = 32'h0001_0000 + ($urandom_range(0, 63) << 5) + $urandom_range(0, 31);
      da = 32'h0002_0000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) wline[32*k +: 32] = $urandom;
      applyStimulus(mode != 1, ia, mode != 0, dw, dr, da, wline);
      runUntilIdle(300, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
